// File: rtl/gate_bank_arbiter_if.sv
// Bundle of requester, gate-bank and response signals for gate_bank_arbiter.
// The slave modport is the arbiter; master is the requesters/bank/consumer side.
interface gate_bank_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] op;
  logic [NREQ-1:0]   gnt;
  logic [3:0]        bank_in;
  logic [7:0]        bank_out;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_data;
  logic              rsp_err;
  logic [7:0]        err_cnt;
  logic              busy;

  modport slave (
    input  req, op, bank_out, rsp_ready,
    output gnt, bank_in, rsp_valid, rsp_id, rsp_data, rsp_err, err_cnt, busy
  );

  modport master (
    output req, op, bank_out, rsp_ready,
    input  gnt, bank_in, rsp_valid, rsp_id, rsp_data, rsp_err, err_cnt, busy
  );
endinterface

// File: rtl/gate_bank_arbiter.sv
// Round-robin sharing of one primitive-gate bank among NREQ requesters, with a
// golden-value comparison on every captured result to flag a faulty or tampered bank.
module gate_bank_arbiter #(
  parameter int NREQ     = 4,
  parameter int BANK_LAT = 1,
  parameter int IDW      = $clog2(NREQ)
) (
  input  logic              CLK,
  input  logic              RST,
  gate_bank_arbiter_if.slave bus
);

  localparam int CNTW = 3;
  localparam int SW   = IDW + 1;
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(BANK_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q,     state_d;
  logic [IDW-1:0]  ptr_q,       ptr_d;
  logic [CNTW-1:0] cnt_q,       cnt_d;
  logic [3:0]      op_q,        op_d;
  logic [NREQ-1:0] gnt_q,       gnt_d;
  logic [3:0]      bank_in_q,   bank_in_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q,    rsp_id_d;
  logic [7:0]      rsp_data_q,  rsp_data_d;
  logic            rsp_err_q,   rsp_err_d;
  logic [7:0]      err_cnt_q,   err_cnt_d;
  logic            busy_q,      busy_d;

  logic            any_req_s;
  logic            win_found_s;
  logic [IDW-1:0]  win_id_s;
  logic [IDW-1:0]  win_next_s;
  logic [3:0]      win_op_s;
  logic [SW-1:0]   sum_s;
  logic [IDW-1:0]  idx_s;
  logic            mismatch_s;

  // Expected bank word: {BUF in1, NOT in1, XNOR, XOR, NOR, OR, NAND, AND}.
  function automatic logic [7:0] golden(input logic [3:0] v);
    golden = {v[0], ~v[0], ~^v, ^v, ~|v, |v, ~&v, &v};
  endfunction

  // Round-robin winner: first set request at or above ptr, wrapping past NREQ-1.
  always_comb begin
    win_found_s = 1'b0;
    win_id_s    = '0;
    sum_s       = '0;
    idx_s       = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum_s = {1'b0, ptr_q} + SW'(i);
      if (sum_s >= SW'(NREQ)) begin
        idx_s = IDW'(sum_s - SW'(NREQ));
      end else begin
        idx_s = IDW'(sum_s);
      end
      if (!win_found_s && bus.req[idx_s]) begin
        win_found_s = 1'b1;
        win_id_s    = idx_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Winner-derived values: operand slice, advanced pointer, request presence.
  always_comb begin
    any_req_s = |bus.req;
    win_op_s  = bus.op[{win_id_s, 2'b00} +: 4];
    if (win_id_s == IDW'(NREQ - 1)) begin
      win_next_s = '0;
    end else begin
      win_next_s = win_id_s + IDW'(1);
    end
    mismatch_s = (bus.bank_out != golden(op_q));
  end

  // FSM next state and all datapath next values; everything holds by default.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    gnt_d       = '0;
    bank_in_d   = bank_in_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    err_cnt_d   = err_cnt_q;
    case (state_q)
      IDLE: begin
        bank_in_d = 4'h0;
        if (any_req_s) begin
          gnt_d     = {{(NREQ-1){1'b0}}, 1'b1} << win_id_s;
          op_d      = win_op_s;
          bank_in_d = win_op_s;
          rsp_id_d  = win_id_s;
          ptr_d     = win_next_s;
          cnt_d     = '0;
          state_d   = EVAL;
        end else begin
          state_d   = IDLE;
        end
      end
      EVAL: begin
        bank_in_d = op_q;
        cnt_d     = cnt_q + CNTW'(1);
        if (cnt_q == LAST_CNT) begin
          rsp_data_d  = bus.bank_out;
          rsp_err_d   = mismatch_s;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
          if (mismatch_s && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end else begin
            err_cnt_d = err_cnt_q;
          end
        end else begin
          state_d = EVAL;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          bank_in_d   = 4'h0;
          state_d     = IDLE;
        end else begin
          bank_in_d   = op_q;
          state_d     = RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        bank_in_d   = 4'h0;
        state_d     = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; RST low aborts any transaction in flight.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      op_q        <= 4'h0;
      gnt_q       <= '0;
      bank_in_q   <= 4'h0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= 8'h00;
      rsp_err_q   <= 1'b0;
      err_cnt_q   <= 8'h00;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      gnt_q       <= gnt_d;
      bank_in_q   <= bank_in_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      err_cnt_q   <= err_cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.bank_in   = bank_in_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.busy      = busy_q;

endmodule

// File: doc/gate_bank_arbiter.md
Name: gate_bank_arbiter

Overview:
Round-robin scheduler that shares one combinational primitive-gate bank between NREQ requesters. The bank has 4 inputs (in1..in4) and 8 outputs (AND, NAND, OR, NOR, XOR, XNOR, NOT in1, BUF in1). The block grants one requester at a time and drives its 4-bit operand onto the bank. After a fixed settle time it captures the bank outputs and returns them with the requester ID. It also checks the captured word against an internally computed golden value, which makes it a runtime Trojan/fault monitor for the shared bank.

Parameters:
NREQ, 4, number of requesters (2..8).
BANK_LAT, 1, cycles bank_in is held before bank_out is sampled (1..4).
IDW, $clog2(NREQ), width of the requester ID.

Ports:
CLK  input  1  clock, rising edge.
RST  input  1  synchronous reset, active-low.
req  input  NREQ  per-requester request level.
op  input  4*NREQ  operands; requester i uses op[4i+3:4i]; bit0=in1, bit1=in2, bit2=in3, bit3=in4.
gnt  output  NREQ  one-hot grant, 1-cycle pulse.
bank_in  output  4  operand driven to the gate bank.
bank_out  input  8  gate bank outputs: bit0 AND, bit1 NAND, bit2 OR, bit3 NOR, bit4 XOR, bit5 XNOR, bit6 NOT in1, bit7 BUF in1.
rsp_valid  output  1  response valid.
rsp_ready  input  1  response accepted.
rsp_id  output  IDW  ID of the granted requester.
rsp_data  output  8  captured bank_out.
rsp_err  output  1  rsp_data differs from golden.
err_cnt  output  8  saturating mismatch count.
busy  output  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-low on RST. While RST=0 at an edge, all of the following clear at that edge: gnt, bank_in, rsp_valid, rsp_id, rsp_data, rsp_err, err_cnt, busy. The state goes to IDLE and the round-robin pointer goes to 0. Reset in any state, including mid-EVAL or mid-RESP, aborts the transaction with no response. Requests still pending afterwards are re-arbitrated from pointer 0.
- FSM states: IDLE, EVAL, RESP.
- IDLE: bank_in=0. If any req bit is high at an edge:
  - choose winner w = first set bit scanning from ptr upward, with wrap-around;
  - at that edge: gnt<=onehot(w), op_q<=op[w], bank_in<=op[w], rsp_id<=w, ptr<=(w+1) mod NREQ, cnt<=0, state<=EVAL.
- gnt is high for exactly the first EVAL cycle, then returns to 0.
- Requester contract: hold req and op stable until gnt is seen, then drop req. A req still high after the transaction completes counts as a new request.
- EVAL: bank_in is held at op_q and cnt increments each cycle. On the edge where cnt==BANK_LAT-1:
  - rsp_data<=bank_out;
  - rsp_err<=(bank_out != golden(op_q));
  - err_cnt increments if mismatch, saturating at 255;
  - rsp_valid<=1, state<=RESP.
- Golden value, bit by bit:
  - bit0 = &op_q, bit1 = ~&op_q;
  - bit2 = |op_q, bit3 = ~|op_q;
  - bit4 = ^op_q, bit5 = ~^op_q;
  - bit6 = ~op_q[0], bit7 = op_q[0].
- RESP: rsp_valid, rsp_id, rsp_data and rsp_err are held stable while rsp_ready=0. bank_in keeps op_q. No new grant is issued. On an edge with rsp_ready=1: rsp_valid<=0, bank_in<=0, state<=IDLE.
- Arbitration restarts at the next edge after returning to IDLE. Minimum spacing between grants is therefore BANK_LAT+2 cycles.
- Latency: req sampled at edge k -> gnt high after edge k -> rsp_valid high after edge k+BANK_LAT.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,NREQ-1,0. No requester waits more than NREQ-1 transactions.
- rsp_err and rsp_data are meaningful only while rsp_valid=1. They retain their last values otherwise.
- err_cnt is never cleared except by reset.

Test Plan:
1. Single request, BANK_LAT=1, ideal bank model; req=0001, op0=4'b1111 -> gnt=0001 for one cycle; rsp_valid one cycle later with rsp_id=0, rsp_data=8'hA5, rsp_err=0. Repeat with op0=4'b0000 -> rsp_data=8'h6A, rsp_err=0.
2. Rotation: req=1111 held continuously, rsp_ready=1, ptr=0 -> grants 0001,0010,0100,1000,0001 and rsp_id 0,1,2,3,0; grant spacing is 3 cycles.
3. Backpressure: rsp_ready=0 for 5 cycles while a second requester is pending -> rsp_valid and rsp_data stay stable and gnt stays 0. Release rsp_ready -> rsp_valid drops next edge, then the pending requester is granted.
4. Fault detection: bank model forces bit4=1; op=4'b1111 -> rsp_data=8'hB5, rsp_err=1, err_cnt=1. Then 300 faulty transactions -> err_cnt saturates at 8'hFF.
5. Reset mid-EVAL: BANK_LAT=3, assert RST=0 in the second EVAL cycle -> after that edge busy=0, rsp_valid=0, bank_in=0, err_cnt=0. Release with req=0100 held -> gnt=0100 on the first IDLE edge.
6. Latency check with BANK_LAT=3: req at edge k -> rsp_valid high after edge k+3; the bank model samples stable bank_in throughout.
